// File: rtl/alu_seq.sv
// Accumulator/result ALU for the shared-bus datapath with registered Z/N/C/V flags and an iterative multiply.
// Latency: single-cycle ops load G one edge after Gin; MUL holds BUSY for N edges, then pulses DONE with G valid.
// Backpressure: the control FSM stalls on BUSY; Gin/FN are ignored during a multiply, while Ain still loads A.
//
// Ports:
//   CLKb  - clock; all state changes on its rising edge
//   RST   - synchronous active-high reset
//   OP    - operand from the shared bus
//   Ain   - load OP into A
//   Gin   - load G with the FN result, or start a multiply when FN=MUL
//   Gout  - drive G onto RES (high-Z otherwise)
//   FN    - operation select
//   RES   - tri-stated result bus
//   FLAGS - {Z,N,C,V}, updated only when G is loaded
//   BUSY  - multiply in progress
//   DONE  - one-cycle pulse when the multiply result is in G
module alu_seq #(
  parameter int N  = 10,
  parameter int CW = $clog2(N + 1)
) (
  input  logic         CLKb,
  input  logic         RST,
  input  logic [N-1:0] OP,
  input  logic         Ain,
  input  logic         Gin,
  input  logic         Gout,
  input  logic [3:0]   FN,
  output logic [N-1:0] RES,
  output logic [3:0]   FLAGS,
  output logic         BUSY,
  output logic         DONE
);

  localparam logic [3:0] FN_LOAD = 4'b0000;
  localparam logic [3:0] FN_COPY = 4'b0001;
  localparam logic [3:0] FN_ADD  = 4'b0010;
  localparam logic [3:0] FN_SUB  = 4'b0011;
  localparam logic [3:0] FN_INV  = 4'b0100;
  localparam logic [3:0] FN_FLP  = 4'b0101;
  localparam logic [3:0] FN_AND  = 4'b0110;
  localparam logic [3:0] FN_OR   = 4'b0111;
  localparam logic [3:0] FN_XOR  = 4'b1000;
  localparam logic [3:0] FN_LSL  = 4'b1001;
  localparam logic [3:0] FN_LSR  = 4'b1010;
  localparam logic [3:0] FN_ASR  = 4'b1011;
  localparam logic [3:0] FN_MUL  = 4'b1100;

  // Width-matched copy of N for the shift-range compare.
  localparam logic [N-1:0] L_N = N[N-1:0];

  typedef enum logic [0:0] {S_IDLE, S_MULT} state_t;

  state_t        r_state;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_g;
  logic [3:0]    r_flags;
  logic          r_busy;
  logic          r_done;
  logic [2*N-1:0] r_mcand;   // multiplicand, shifted left one place per step
  logic [N-1:0]  r_mplier;   // multiplier, shifted right so bit 0 is the current bit
  logic [2*N-1:0] r_acc;
  logic [CW-1:0] r_cnt;

  logic [N:0]     w_add;
  logic [N:0]     w_sub;
  logic           w_big_sh;
  logic [N-1:0]   w_res;
  logic           w_c;
  logic           w_v;
  logic [2*N-1:0] w_prod;

  assign w_add    = {1'b0, r_a} + {1'b0, OP};
  // The extra top bit of the difference is the unsigned borrow (A < OP).
  assign w_sub    = {1'b0, r_a} - {1'b0, OP};
  assign w_big_sh = (OP >= L_N);
  assign w_prod   = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (FN)
      FN_LOAD, FN_COPY: w_res = OP;
      FN_ADD: begin
        w_res = w_add[N-1:0];
        w_c   = w_add[N];
        w_v   = (r_a[N-1] == OP[N-1]) && (w_add[N-1] != r_a[N-1]);
      end
      FN_SUB: begin
        w_res = w_sub[N-1:0];
        w_c   = w_sub[N];
        w_v   = (r_a[N-1] != OP[N-1]) && (w_sub[N-1] != r_a[N-1]);
      end
      FN_INV: w_res = (~OP) + 1'b1;
      FN_FLP: w_res = ~OP;
      FN_AND: w_res = r_a & OP;
      FN_OR:  w_res = r_a | OP;
      FN_XOR: w_res = r_a ^ OP;
      FN_LSL: w_res = w_big_sh ? '0 : (r_a << OP);
      FN_LSR: w_res = w_big_sh ? '0 : (r_a >> OP);
      FN_ASR: w_res = w_big_sh ? {N{r_a[N-1]}} : $unsigned($signed(r_a) >>> OP);
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge CLKb) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_g      <= '0;
      r_flags  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      if (Ain) r_a <= OP;
      case (r_state)
        S_IDLE: begin
          if (Gin) begin
            if (FN == FN_MUL) begin
              r_mcand  <= {{N{1'b0}}, r_a};
              r_mplier <= OP;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_busy   <= 1'b1;
              r_state  <= S_MULT;
            end else begin
              r_g     <= w_res;
              r_flags <= {(w_res == '0), w_res[N-1], w_c, w_v};
            end
          end
        end
        S_MULT: begin
          r_acc    <= w_prod;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          // Nth step: w_prod already holds the full product.
          if (r_cnt == CW'(N - 1)) begin
            r_g     <= w_prod[N-1:0];
            r_flags <= {(w_prod[N-1:0] == '0), w_prod[N-1], |w_prod[2*N-1:N], 1'b0};
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign RES   = Gout ? r_g : {N{1'bz}};
  assign FLAGS = r_flags;
  assign BUSY  = r_busy;
  assign DONE  = r_done;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int N = 10;
  localparam int M = 1 << N;

  logic         CLKb = 1'b0;
  logic         RST;
  logic [N-1:0] OP;
  logic         Ain;
  logic         Gin;
  logic         Gout;
  logic [3:0]   FN;
  wire  [N-1:0] RES;
  logic [3:0]   FLAGS;
  logic         BUSY;
  logic         DONE;

  int checks   = 0;
  int failures = 0;
  int ma = 0;   // reference A
  int mg = 0;   // reference G

  alu_seq #(.N(N)) dut (
    .CLKb (CLKb),
    .RST  (RST),
    .OP   (OP),
    .Ain  (Ain),
    .Gin  (Gin),
    .Gout (Gout),
    .FN   (FN),
    .RES  (RES),
    .FLAGS(FLAGS),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  always #5 CLKb = ~CLKb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLKb);
    #1;
  endtask

  // Reference model: plain integer arithmetic on the opcode rules.
  function automatic void model(input int fn, input int a, input int b,
                                output int r, output int fl);
    int sa, sb, s2;
    longint p;
    bit c, v;
    c  = 1'b0;
    v  = 1'b0;
    r  = 0;
    sa = (a >= M / 2) ? a - M : a;
    sb = (b >= M / 2) ? b - M : b;
    case (fn)
      0, 1: r = b;
      2: begin
        r  = (a + b) % M;
        c  = (a + b) >= M;
        s2 = sa + sb;
        v  = (s2 > M / 2 - 1) || (s2 < -(M / 2));
      end
      3: begin
        r  = (a - b + M) % M;
        c  = a < b;
        s2 = sa - sb;
        v  = (s2 > M / 2 - 1) || (s2 < -(M / 2));
      end
      4: r = (M - b) % M;
      5: r = M - 1 - b;
      6: r = a & b;
      7: r = a | b;
      8: r = a ^ b;
      9:  r = (b >= N) ? 0 : (a << b) % M;
      10: r = (b >= N) ? 0 : a >> b;
      11: r = (b >= N) ? ((sa < 0) ? M - 1 : 0) : ((sa >>> b) + M) % M;
      12: begin
        p = longint'(a) * longint'(b);
        r = int'(p % M);
        c = p >= M;
      end
      default: r = 0;
    endcase
    fl = ((r == 0) ? 8 : 0) + ((r >= M / 2) ? 4 : 0) + (c ? 2 : 0) + (v ? 1 : 0);
  endfunction

  task automatic load_a(input int a);
    OP  = a[N-1:0];
    Ain = 1'b1;
    step();
    Ain = 1'b0;
    ma  = a;
  endtask

  task automatic exec(input int fn, input int b, input string tag);
    int r, fl;
    OP  = b[N-1:0];
    FN  = fn[3:0];
    Gin = 1'b1;
    step();
    Gin = 1'b0;
    model(fn, ma, b, r, fl);
    mg = r;
    chk({tag, "_g"}, RES, r);
    chk({tag, "_f"}, FLAGS, fl);
  endtask

  // inject: 0 none, 1 Gin/ADD pulse mid-multiply, 2 Ain of 0x111 mid-multiply
  task automatic run_mul(input int a, input int b, input int inject, input string tag);
    int r, fl, busy_cnt, cyc;
    load_a(a);
    OP  = b[N-1:0];
    FN  = 4'd12;
    Gin = 1'b1;
    step();
    Gin = 1'b0;
    chk({tag, "_busy_start"}, BUSY, 1);
    model(12, a, b, r, fl);
    busy_cnt = 0;
    cyc      = 0;
    while (BUSY === 1'b1 && cyc < 40) begin
      busy_cnt++;
      chk({tag, "_g_hold"}, RES, mg);
      chk({tag, "_done_early"}, DONE, 0);
      if (inject == 1 && cyc == 3) begin FN = 4'd2; OP = 10'h001; Gin = 1'b1; end
      if (inject == 1 && cyc == 4) Gin = 1'b0;
      if (inject == 2 && cyc == 5) begin OP = 10'h111; Ain = 1'b1; end
      if (inject == 2 && cyc == 6) begin Ain = 1'b0; ma = 32'h111; end
      step();
      cyc++;
    end
    chk({tag, "_busy_cycles"}, busy_cnt, N);
    chk({tag, "_done"}, DONE, 1);
    chk({tag, "_g"}, RES, r);
    chk({tag, "_f"}, FLAGS, fl);
    mg = r;
    step();
    chk({tag, "_done_pulse"}, DONE, 0);
  endtask

  initial begin
    logic [31:0] zexp;
    int fn, a, b, done_cnt;

    zexp = {22'b0, {N{1'bz}}};
    RST = 1'b1; Ain = 1'b0; Gin = 1'b0; Gout = 1'b1; OP = '0; FN = '0;
    step();
    step();
    RST = 1'b0;
    chk("rst_g", RES, 0);
    chk("rst_flags", FLAGS, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);

    load_a(10'h3FF);
    exec(2, 10'h001, "tp_add");
    chk("tp_add_lit", RES, 10'h000);
    chk("tp_add_flags_lit", FLAGS, 4'b1010);
    Gout = 1'b0;
    #1;
    chk("tp_res_highz", RES, zexp);
    Gout = 1'b1;
    #1;
    chk("tp_res_drive", RES, 10'h000);

    load_a(10'h200);
    exec(3, 10'h001, "tp_sub1");
    chk("tp_sub1_lit", RES, 10'h1FF);
    chk("tp_sub1_flags_lit", FLAGS, 4'b0001);
    load_a(10'h005);
    exec(3, 10'h006, "tp_sub2");
    chk("tp_sub2_lit", RES, 10'h3FF);
    chk("tp_sub2_flags_lit", FLAGS, 4'b0110);

    load_a(10'h300);
    exec(11, 3, "tp_asr3");
    chk("tp_asr3_lit", RES, 10'h3E0);
    exec(11, 12, "tp_asr12");
    chk("tp_asr12_lit", RES, 10'h3FF);
    exec(9, 12, "tp_lsl12");
    chk("tp_lsl12_flags_lit", FLAGS, 4'b1000);
    exec(10, 4, "tp_lsr4");
    chk("tp_lsr4_lit", RES, 10'h030);

    run_mul(25, 40, 0, "mul1");
    chk("mul1_lit", RES, 10'h3E8);
    chk("mul1_flags_lit", FLAGS, 4'b0100);
    run_mul(100, 20, 1, "mul2");
    chk("mul2_lit", RES, 10'h3D0);
    chk("mul2_flags_lit", FLAGS, 4'b0110);

    // Reset on the 5th multiply step aborts it without DONE.
    load_a(7);
    OP = 10'd9; FN = 4'd12; Gin = 1'b1;
    step();
    Gin = 1'b0;
    repeat (4) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    ma = 0; mg = 0;
    chk("abort_busy", BUSY, 0);
    chk("abort_g", RES, 0);
    chk("abort_flags", FLAGS, 0);
    chk("abort_done", DONE, 0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (DONE === 1'b1) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    load_a(10'h0F0);
    exec(2, 10'h00F, "post_abort_add");
    chk("post_abort_add_lit", RES, 10'h0FF);

    run_mul(3, 5, 2, "mul_ain");
    chk("mul_ain_lit", RES, 15);
    exec(7, 0, "ain_readback");
    chk("ain_readback_lit", RES, 10'h111);
    exec(14, 10'h055, "fn14");
    chk("fn14_flags_lit", FLAGS, 4'b1000);

    for (int i = 0; i < 120; i++) begin
      fn = $urandom_range(0, 15);
      if (fn == 12) fn = 13;
      a = $urandom_range(0, M - 1);
      b = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : $urandom_range(0, M - 1);
      load_a(a);
      exec(fn, b, "rand");
    end
    for (int i = 0; i < 4; i++) begin
      run_mul($urandom_range(0, M - 1), $urandom_range(0, M - 1), 0, "rand_mul");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
